// File: rtl/cr_huf_comp_st_is.sv
// Symbol frequency accumulator: folds 4-lane (symbol, count) beats into a per-symbol table, then drains nonzero entries plus a trailer.
// Latency: table updated one cycle after an input beat; nonzero index k leaves two cycles after the end-of-block beat plus k plus stalls.
// Backpressure: output register holds while is_sq_vld && !sq_is_rdy and the scan pauses; input beats outside ACCUM are dropped and flagged as overrun.

`ifndef CREOLE_HC_ST_SYMB_WIDTH
`define CREOLE_HC_ST_SYMB_WIDTH 10
`endif
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 10
`endif

package cr_huf_comp_st_is_pkg;
    typedef enum logic [1:0] {
        MIDDLE    = 2'd0,
        LAST      = 2'd1,
        PASS_THRU = 2'd2,
        MORE      = 2'd3
    } e_pipe_eob;
endpackage

module cr_huf_comp_st_is
    import cr_huf_comp_st_is_pkg::*;
#(
    parameter int MAX_SYMBOL_TABLE_DEPTH = 584,
    parameter int FREQ_WIDTH             = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [3:0]                                   sc_is_vld,
    input  logic [3:0][2:0]                              sc_is_cnt,
    input  logic [3:0][`CREOLE_HC_ST_SYMB_WIDTH-1:0]     sc_is_symbol,
    input  logic [`CREOLE_HC_SEQID_WIDTH-1:0]            sc_is_seq_id,
    input  e_pipe_eob                                    sc_is_eob,
    input  logic                                         sc_is_build_error,
    output logic                                         is_sc_rd,
    output logic                                         is_sq_vld,
    input  logic                                         sq_is_rdy,
    output logic [`CREOLE_HC_ST_SYMB_WIDTH-1:0]          is_sq_symbol,
    output logic [FREQ_WIDTH-1:0]                        is_sq_freq,
    output logic                                         is_sq_last,
    output logic [`CREOLE_HC_SEQID_WIDTH-1:0]            is_sq_seq_id,
    output e_pipe_eob                                    is_sq_eob,
    output logic                                         is_sq_build_error,
    output logic                                         is_sq_sat
);

    localparam int SW    = `CREOLE_HC_ST_SYMB_WIDTH;
    localparam int QW    = `CREOLE_HC_SEQID_WIDTH;
    localparam int DEPTH = MAX_SYMBOL_TABLE_DEPTH;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_TRAIL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         ptr_q, ptr_d;
    logic [FREQ_WIDTH-1:0] freq_q [DEPTH];
    logic [FREQ_WIDTH-1:0] freq_d [DEPTH];

    // Sticky per-block status and fields captured from the end-of-block beat.
    logic                  sat_q, sat_d;
    logic                  range_q, range_d;
    logic                  ovr_q, ovr_d;
    logic [QW-1:0]         cap_seq_q, cap_seq_d;
    e_pipe_eob             cap_eob_q, cap_eob_d;
    logic                  cap_be_q, cap_be_d;

    // Output register.
    logic                  out_vld_q, out_vld_d;
    logic [SW-1:0]         out_sym_q, out_sym_d;
    logic [FREQ_WIDTH-1:0] out_freq_q, out_freq_d;
    logic                  out_last_q, out_last_d;
    logic [QW-1:0]         out_seq_q, out_seq_d;
    e_pipe_eob             out_eob_q, out_eob_d;
    logic                  out_be_q, out_be_d;
    logic                  out_sat_q, out_sat_d;
    logic                  rd_q, rd_d;

    logic                  stall;
    logic                  accept;
    logic [FREQ_WIDTH:0]   acc_sum;

    assign stall  = out_vld_q && !sq_is_rdy;
    assign accept = out_vld_q && sq_is_rdy;

    // Next-state logic: accumulate, scan/drain, trailer and handshake completion.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        freq_d     = freq_q;
        sat_d      = sat_q;
        range_d    = range_q;
        ovr_d      = ovr_q;
        cap_seq_d  = cap_seq_q;
        cap_eob_d  = cap_eob_q;
        cap_be_d   = cap_be_q;
        out_vld_d  = out_vld_q;
        out_sym_d  = out_sym_q;
        out_freq_d = out_freq_q;
        out_last_d = out_last_q;
        out_seq_d  = out_seq_q;
        out_eob_d  = out_eob_q;
        out_be_d   = out_be_q;
        out_sat_d  = out_sat_q;
        rd_d       = 1'b0;
        acc_sum    = '0;

        if (accept) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            ST_ACCUM: begin
                // Lanes carry distinct symbols, so every lane reads the
                // registered count and no lane sees another lane's update.
                for (int l = 0; l < 4; l++) begin
                    if (sc_is_vld[l]) begin
                        if (32'(sc_is_symbol[l]) < 32'(DEPTH)) begin
                            acc_sum = {1'b0, freq_q[sc_is_symbol[l]]} + (FREQ_WIDTH+1)'(sc_is_cnt[l]);
                            if (acc_sum[FREQ_WIDTH]) begin
                                freq_d[sc_is_symbol[l]] = '1;
                                sat_d                   = 1'b1;
                            end else begin
                                freq_d[sc_is_symbol[l]] = acc_sum[FREQ_WIDTH-1:0];
                            end
                        end else begin
                            range_d = 1'b1;
                        end
                    end
                end
                if (sc_is_eob != MIDDLE) begin
                    cap_seq_d = sc_is_seq_id;
                    cap_eob_d = sc_is_eob;
                    cap_be_d  = sc_is_build_error;
                    ptr_d     = '0;
                    state_d   = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (|sc_is_vld) begin
                    ovr_d = 1'b1;
                end
                if (!stall) begin
                    if (freq_q[ptr_q] != '0) begin
                        out_vld_d     = 1'b1;
                        out_sym_d     = ptr_q;
                        out_freq_d    = freq_q[ptr_q];
                        out_last_d    = 1'b0;
                        out_seq_d     = '0;
                        out_eob_d     = MIDDLE;
                        out_be_d      = 1'b0;
                        out_sat_d     = 1'b0;
                        freq_d[ptr_q] = '0;
                    end
                    if (32'(ptr_q) == 32'(DEPTH - 1)) begin
                        ptr_d   = '0;
                        state_d = ST_TRAIL;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            ST_TRAIL: begin
                if (|sc_is_vld) begin
                    ovr_d = 1'b1;
                end
                if (!stall) begin
                    out_vld_d  = 1'b1;
                    out_sym_d  = '0;
                    out_freq_d = '0;
                    out_last_d = 1'b1;
                    out_seq_d  = cap_seq_q;
                    out_eob_d  = cap_eob_q;
                    out_be_d   = cap_be_q | ovr_d | range_q;
                    out_sat_d  = sat_q;
                    state_d    = ST_DONE;
                end
            end

            default: begin
                if (|sc_is_vld) begin
                    ovr_d = 1'b1;
                end
                if (accept) begin
                    // A beat dropped in this very cycle belongs to the next block.
                    rd_d       = 1'b1;
                    sat_d      = 1'b0;
                    range_d    = 1'b0;
                    ovr_d      = |sc_is_vld;
                    cap_seq_d  = '0;
                    cap_eob_d  = MIDDLE;
                    cap_be_d   = 1'b0;
                    out_sym_d  = '0;
                    out_freq_d = '0;
                    out_last_d = 1'b0;
                    out_seq_d  = '0;
                    out_eob_d  = MIDDLE;
                    out_be_d   = 1'b0;
                    out_sat_d  = 1'b0;
                    state_d    = ST_ACCUM;
                end
            end
        endcase
    end

    // State, table and output registers; reset empties the table and aborts any drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            ptr_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                freq_q[i] <= '0;
            end
            sat_q      <= 1'b0;
            range_q    <= 1'b0;
            ovr_q      <= 1'b0;
            cap_seq_q  <= '0;
            cap_eob_q  <= MIDDLE;
            cap_be_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_sym_q  <= '0;
            out_freq_q <= '0;
            out_last_q <= 1'b0;
            out_seq_q  <= '0;
            out_eob_q  <= MIDDLE;
            out_be_q   <= 1'b0;
            out_sat_q  <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            freq_q     <= freq_d;
            sat_q      <= sat_d;
            range_q    <= range_d;
            ovr_q      <= ovr_d;
            cap_seq_q  <= cap_seq_d;
            cap_eob_q  <= cap_eob_d;
            cap_be_q   <= cap_be_d;
            out_vld_q  <= out_vld_d;
            out_sym_q  <= out_sym_d;
            out_freq_q <= out_freq_d;
            out_last_q <= out_last_d;
            out_seq_q  <= out_seq_d;
            out_eob_q  <= out_eob_d;
            out_be_q   <= out_be_d;
            out_sat_q  <= out_sat_d;
            rd_q       <= rd_d;
        end
    end

    assign is_sc_rd          = rd_q;
    assign is_sq_vld         = out_vld_q;
    assign is_sq_symbol      = out_sym_q;
    assign is_sq_freq        = out_freq_q;
    assign is_sq_last        = out_last_q;
    assign is_sq_seq_id      = out_seq_q;
    assign is_sq_eob         = out_eob_q;
    assign is_sq_build_error = out_be_q;
    assign is_sq_sat         = out_sat_q;

endmodule

// File: tb/tb_cr_huf_comp_st_is.sv
// Bench for cr_huf_comp_st_is: directed blocks, expected beats queued at issue time, monitors pop and compare on each transfer.
// Two instances: default 16-bit counters, and 4-bit counters for the saturation case.
// Ready is held high or toggled per cycle from the stimulus process.
`timescale 1ns/1ps

`ifndef CREOLE_HC_ST_SYMB_WIDTH
`define CREOLE_HC_ST_SYMB_WIDTH 10
`endif
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 10
`endif

module tb_cr_huf_comp_st_is;
    import cr_huf_comp_st_is_pkg::*;

    localparam int SW    = `CREOLE_HC_ST_SYMB_WIDTH;
    localparam int QW    = `CREOLE_HC_SEQID_WIDTH;
    localparam int DEPTH = 584;

    typedef struct {
        int        sym;
        int        freq;
        bit        last;
        int        seq;
        e_pipe_eob eob;
        bit        be;
        bit        sat;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [3:0]            in_vld1 = '0, in_vld2 = '0;
    logic [3:0][2:0]       in_cnt = '0;
    logic [3:0][SW-1:0]    in_sym = '0;
    logic [QW-1:0]         in_seq = '0;
    e_pipe_eob             in_eob1 = MIDDLE, in_eob2 = MIDDLE;
    logic                  in_be = 1'b0;
    logic                  rdy = 1'b1;

    logic                  o1_rd, o1_vld, o1_last, o1_be, o1_sat;
    logic [SW-1:0]         o1_sym;
    logic [15:0]           o1_freq;
    logic [QW-1:0]         o1_seq;
    e_pipe_eob             o1_eob;
    logic                  o2_rd, o2_vld, o2_last, o2_be, o2_sat;
    logic [SW-1:0]         o2_sym;
    logic [3:0]            o2_freq;
    logic [QW-1:0]         o2_seq;
    e_pipe_eob             o2_eob;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int rd_cnt1 = 0, rd_cnt2 = 0;
    int eob_cyc1 = 0, trail_cyc1 = 0;
    bit trail_seen1 = 0;
    bit hold1_v = 0;
    int hold1_sym, hold1_freq, hold1_last;
    exp_t e1, e2;

    cr_huf_comp_st_is #(.MAX_SYMBOL_TABLE_DEPTH(DEPTH), .FREQ_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .sc_is_vld(in_vld1), .sc_is_cnt(in_cnt), .sc_is_symbol(in_sym),
        .sc_is_seq_id(in_seq), .sc_is_eob(in_eob1), .sc_is_build_error(in_be),
        .is_sc_rd(o1_rd), .is_sq_vld(o1_vld), .sq_is_rdy(rdy),
        .is_sq_symbol(o1_sym), .is_sq_freq(o1_freq), .is_sq_last(o1_last),
        .is_sq_seq_id(o1_seq), .is_sq_eob(o1_eob),
        .is_sq_build_error(o1_be), .is_sq_sat(o1_sat)
    );

    cr_huf_comp_st_is #(.MAX_SYMBOL_TABLE_DEPTH(DEPTH), .FREQ_WIDTH(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .sc_is_vld(in_vld2), .sc_is_cnt(in_cnt), .sc_is_symbol(in_sym),
        .sc_is_seq_id(in_seq), .sc_is_eob(in_eob2), .sc_is_build_error(in_be),
        .is_sc_rd(o2_rd), .is_sq_vld(o2_vld), .sq_is_rdy(rdy),
        .is_sq_symbol(o2_sym), .is_sq_freq(o2_freq), .is_sq_last(o2_last),
        .is_sq_seq_id(o2_seq), .is_sq_eob(o2_eob),
        .is_sq_build_error(o2_be), .is_sq_sat(o2_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic cmp_beat(input string tag, input exp_t e, input int sym, input int freq,
                            input bit last, input int seq, input e_pipe_eob eob,
                            input bit be, input bit sat);
        chk({tag, "_sym"},  sym,  e.sym);
        chk({tag, "_freq"}, freq, e.freq);
        chk({tag, "_last"}, last, e.last);
        chk({tag, "_eob"},  eob,  e.eob);
        if (e.last) begin
            chk({tag, "_seq"}, seq, e.seq);
            chk({tag, "_be"},  be,  e.be);
            chk({tag, "_sat"}, sat, e.sat);
        end
    endtask

    task automatic push_dat(input int d, input int sym, input int freq);
        exp_t e;
        e = '{sym: sym, freq: freq, last: 1'b0, seq: 0, eob: MIDDLE, be: 1'b0, sat: 1'b0};
        if (d == 1) q1.push_back(e); else q2.push_back(e);
    endtask

    task automatic push_trl(input int d, input int seq, input e_pipe_eob eob, input bit be, input bit sat);
        exp_t e;
        e = '{sym: 0, freq: 0, last: 1'b1, seq: seq, eob: eob, be: be, sat: sat};
        if (d == 1) q1.push_back(e); else q2.push_back(e);
    endtask

    // Monitor for the 16-bit instance: transfers, hold stability, trailer timing, read pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold1_v = 0;
        end else begin
            if (hold1_v) begin
                chk("hold_sym",  o1_sym,  hold1_sym);
                chk("hold_freq", o1_freq, hold1_freq);
                chk("hold_last", o1_last, hold1_last);
            end
            hold1_v    = o1_vld && !rdy;
            hold1_sym  = int'(o1_sym);
            hold1_freq = int'(o1_freq);
            hold1_last = int'(o1_last);
            if (o1_vld && o1_last && !trail_seen1) begin
                trail_seen1 = 1;
                trail_cyc1  = cyc;
            end
            if (o1_vld && rdy) begin
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_beat_sym", o1_sym, -1);
                end else begin
                    e1 = q1.pop_front();
                    cmp_beat("dut1", e1, int'(o1_sym), int'(o1_freq), o1_last, int'(o1_seq), o1_eob, o1_be, o1_sat);
                end
            end
            if (o1_rd) rd_cnt1++;
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o2_vld && rdy) begin
                if (q2.size() == 0) begin
                    chk("dut2_unexpected_beat_sym", o2_sym, -1);
                end else begin
                    e2 = q2.pop_front();
                    cmp_beat("dut2", e2, int'(o2_sym), int'(o2_freq), o2_last, int'(o2_seq), o2_eob, o2_be, o2_sat);
                end
            end
            if (o2_rd) rd_cnt2++;
        end
    end

    // One input beat; returns 1ns after the capturing edge with inputs idled.
    task automatic send(input int d, input logic [3:0] v,
                        input int s0, input int c0, input int s1, input int c1,
                        input int s2, input int c2, input e_pipe_eob eob, input int seq);
        in_sym[0] = SW'(s0); in_cnt[0] = 3'(c0);
        in_sym[1] = SW'(s1); in_cnt[1] = 3'(c1);
        in_sym[2] = SW'(s2); in_cnt[2] = 3'(c2);
        in_sym[3] = '0;      in_cnt[3] = '0;
        in_seq    = QW'(seq);
        if (d == 1) begin in_vld1 = v; in_eob1 = eob; end
        else        begin in_vld2 = v; in_eob2 = eob; end
        if (eob != MIDDLE && d == 1) trail_seen1 = 0;
        @(posedge clk);
        #1;
        if (eob != MIDDLE && d == 1) eob_cyc1 = cyc;
        in_vld1 = '0; in_vld2 = '0;
        in_eob1 = MIDDLE; in_eob2 = MIDDLE;
        in_sym  = '0; in_cnt = '0; in_seq = '0;
    endtask

    // Drive ready (held or toggling) until the drain completes, bounded.
    task automatic wait_done(input int d, input bit toggle);
        int base;
        int j;
        base = (d == 1) ? rd_cnt1 : rd_cnt2;
        j = 0;
        while (((d == 1) ? rd_cnt1 : rd_cnt2) == base && j < 3000) begin
            rdy = toggle ? j[0] : 1'b1;
            @(posedge clk);
            #1;
            j++;
        end
        rdy = 1'b1;
        chk("drain_completed_in_budget", (j < 3000), 1);
        chk("sc_rd_pulse_count", ((d == 1) ? rd_cnt1 : rd_cnt2) - base, 1);
        @(negedge clk);
        chk("sc_rd_one_cycle", (d == 1) ? o1_rd : o2_rd, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #23;
        chk("rst_vld",    o1_vld, 0);
        chk("rst_sc_rd",  o1_rd, 0);
        chk("rst_last",   o1_last, 0);
        chk("rst_sym",    o1_sym, 0);
        chk("rst_freq",   o1_freq, 0);
        chk("rst_eob",    o1_eob, MIDDLE);
        chk("rst_be",     o1_be, 0);
        chk("rst_vld2",   o2_vld, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single beat: lane 2 repeats sym 5 but is not valid.
        push_dat(1, 5, 2); push_dat(1, 9, 1); push_trl(1, 3, LAST, 0, 0);
        send(1, 4'b0011, 5, 2, 9, 1, 5, 3, LAST, 3);
        wait_done(1, 0);
        chk("trailer_offset_rdy_high", trail_cyc1 - eob_cyc1, DEPTH + 1);

        // Cross-beat accumulation: 5*4 + 3.
        push_dat(1, 100, 23); push_trl(1, 7, LAST, 0, 0);
        for (int i = 0; i < 5; i++) send(1, 4'b0001, 100, 4, 0, 0, 0, 0, MIDDLE, 0);
        send(1, 4'b0001, 100, 3, 0, 0, 0, 0, LAST, 7);
        wait_done(1, 0);

        // Backpressure: each beat and the trailer land on a low-ready cycle.
        push_dat(1, 1, 1); push_dat(1, 10, 2); push_dat(1, 21, 3); push_trl(1, 9, PASS_THRU, 0, 0);
        send(1, 4'b0111, 1, 1, 10, 2, 21, 3, PASS_THRU, 9);
        wait_done(1, 1);
        chk("trailer_offset_toggle", trail_cyc1 - eob_cyc1, DEPTH + 4);

        // Saturation and range on the 4-bit instance.
        push_dat(2, 7, 15); push_trl(2, 5, LAST, 1, 1);
        send(2, 4'b0011, 7, 4, 600, 1, 0, 0, MIDDLE, 0);
        for (int i = 0; i < 3; i++) send(2, 4'b0001, 7, 4, 0, 0, 0, 0, MIDDLE, 0);
        send(2, 4'b0001, 7, 4, 0, 0, 0, 0, LAST, 5);
        wait_done(2, 0);

        // Empty block: trailer only.
        push_trl(1, 11, LAST, 0, 0);
        send(1, 4'b0000, 0, 0, 0, 0, 0, 0, LAST, 11);
        wait_done(1, 0);

        // Overrun during scan; the dropped sym 60 never appears.
        push_dat(1, 50, 1); push_trl(1, 12, LAST, 1, 0);
        send(1, 4'b0001, 50, 1, 0, 0, 0, 0, LAST, 12);
        send(1, 4'b0001, 60, 2, 0, 0, 0, 0, MIDDLE, 0);
        wait_done(1, 0);
        push_dat(1, 61, 1); push_trl(1, 13, LAST, 0, 0);
        send(1, 4'b0001, 61, 1, 0, 0, 0, 0, LAST, 13);
        wait_done(1, 0);

        // Reset mid-scan: sym 2 drains, sym 300 is discarded by reset.
        push_dat(1, 2, 1);
        send(1, 4'b0011, 2, 1, 300, 2, 0, 0, LAST, 14);
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld",  o1_vld, 0);
        chk("midrst_sym",  o1_sym, 0);
        chk("midrst_freq", o1_freq, 0);
        chk("midrst_eob",  o1_eob, MIDDLE);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_pending_beats", q1.size(), 0);
        @(posedge clk); #1;
        push_dat(1, 1, 1); push_trl(1, 15, LAST, 0, 0);
        send(1, 4'b0001, 1, 1, 0, 0, 0, 0, LAST, 15);
        wait_done(1, 0);

        repeat (5) @(posedge clk);
        chk("q1_empty_at_end", q1.size(), 0);
        chk("q2_empty_at_end", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
